// File: rtl/seg_pkg.sv
// Shared types and constants for the multiplexed seven-segment scan controller.
package seg_pkg;

    localparam int unsigned BCD_W   = 4;
    localparam int unsigned BCD_MAX = 9;
    localparam int unsigned DEC_W   = 8;

    typedef logic [BCD_W-1:0] bcd_t;

    // True when the nibble is a displayable decimal digit.
    function automatic logic bcd_valid(input bcd_t d);
        return d <= bcd_t'(BCD_MAX);
    endfunction

endpackage

// File: rtl/seg_prescaler.sv
// Slot-rate prescaler: tick_c is high for the one cycle the count reaches PRESCALE-1.
module seg_prescaler #(
    parameter int unsigned PRESCALE = 50000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick_c
);

    localparam int unsigned CNT_W = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick_c = (cnt_q == CNT_W'(PRESCALE - 1));

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (tick_c) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed BCD display scanner with tear-free double-buffered loads.
// Define SEG_SCAN_LZB_EN to blank leading zeros above the most significant nonzero digit.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int unsigned N_DIGITS = 4,
    parameter int unsigned PRESCALE = 50000
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        load,
    input  logic [BCD_W*N_DIGITS-1:0]   value_in,
    output logic                        ready,
    output logic [DEC_W-1:0]            dec_out,
    output logic [N_DIGITS-1:0]         an_n,
    output logic                        frame_tick
);

    localparam int unsigned IDX_W = $clog2(N_DIGITS);
    localparam int unsigned VAL_W = BCD_W * N_DIGITS;

    logic                slot_tick_c;
    logic                wrap_c;

    logic [IDX_W-1:0]    idx_q,      idx_d;
    logic [VAL_W-1:0]    shadow_q,   shadow_d;
    logic [VAL_W-1:0]    display_q,  display_d;
    logic                pending_q,  pending_d;
    logic                ready_q,    ready_d;
    logic [N_DIGITS-1:0] an_n_q,     an_n_d;
    logic [DEC_W-1:0]    dec_out_q,  dec_out_d;
    logic                frame_q,    frame_d;

    bcd_t                disp_digit_c [N_DIGITS];
    logic [N_DIGITS-1:0] lit_c;
    bcd_t                cur_digit_c;
    logic                blank_c;

    seg_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk    (clk),
        .rst_n  (rst_n),
        .tick_c (slot_tick_c)
    );

    // Scan index, shadow/display double buffer and handshake.
    always_comb begin
        idx_d     = idx_q;
        shadow_d  = shadow_q;
        display_d = display_q;
        pending_d = pending_q;
        wrap_c    = slot_tick_c && (idx_q == IDX_W'(N_DIGITS - 1));

        if (slot_tick_c) begin
            idx_d = wrap_c ? '0 : idx_q + IDX_W'(1);
        end

        // A load taken on the wrap cycle only fills the shadow; pending was clear.
        if (load && ready_q) begin
            shadow_d  = value_in;
            pending_d = 1'b1;
        end else if (wrap_c && pending_q) begin
            display_d = shadow_q;
            pending_d = 1'b0;
        end

        ready_d = ~pending_d;
        frame_d = wrap_c;
    end

    // Digit lookup and blanking for the current slot.
    always_comb begin
        for (int i = 0; i < int'(N_DIGITS); i++) begin
            disp_digit_c[i] = display_q[i*BCD_W +: BCD_W];
        end
`ifdef SEG_SCAN_LZB_EN
        lit_c = '0;
        begin : lzb
            logic seen;
            seen = 1'b0;
            for (int i = int'(N_DIGITS) - 1; i >= 0; i--) begin
                seen     = seen | (disp_digit_c[i] != '0) | (i == 0);
                lit_c[i] = seen;
            end
        end
`else
        lit_c = '1;
`endif
        cur_digit_c = disp_digit_c[idx_q];
        blank_c     = !lit_c[idx_q] || !bcd_valid(cur_digit_c);
        an_n_d      = blank_c ? '1 : ~(N_DIGITS'(1) << idx_q);
        dec_out_d   = blank_c ? '0 : DEC_W'(cur_digit_c);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q     <= '0;
            shadow_q  <= '0;
            display_q <= '0;
            pending_q <= 1'b0;
            ready_q   <= 1'b1;
            an_n_q    <= '1;
            dec_out_q <= '0;
            frame_q   <= 1'b0;
        end else begin
            idx_q     <= idx_d;
            shadow_q  <= shadow_d;
            display_q <= display_d;
            pending_q <= pending_d;
            ready_q   <= ready_d;
            an_n_q    <= an_n_d;
            dec_out_q <= dec_out_d;
            frame_q   <= frame_d;
        end
    end

    assign ready      = ready_q;
    assign an_n       = an_n_q;
    assign dec_out    = dec_out_q;
    assign frame_tick = frame_q;

endmodule
